// File: rtl/blink_led.sv
// Square-wave LED driver: led holds each level for HALF_PERIOD clocks, and
// toggle strobes high for the cycle after every led inversion.
module blink_led #(
  parameter int CLK_FREQ   = 128000000,
  parameter int BLINK_FREQ = 1
) (
  input  logic clk_128M,
  input  logic rst,
  output logic led,
  output logic toggle
);

  localparam int RAW_HALF    = CLK_FREQ / (2 * BLINK_FREQ);
  localparam int HALF_PERIOD = (RAW_HALF < 1) ? 1 : RAW_HALF;
  localparam int CNT_W       = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(HALF_PERIOD - 1);

  // NOTE: declaration initialisers give the power-up state, so the block runs
  // correctly even when rst is tied low; they are not a substitute for reset.
  logic [CNT_W-1:0] cnt_q    = '0;
  logic             led_q    = 1'b0;
  logic             toggle_q = 1'b0;

  logic [CNT_W-1:0] cnt_d;
  logic             led_d;
  logic             toggle_d;
  logic             wrap;

  always_comb begin
    wrap     = (cnt_q == TERM_CNT);
    cnt_d    = wrap ? '0 : cnt_q + 1'b1;
    led_d    = wrap ? ~led_q : led_q;
    toggle_d = wrap;
  end

  // NOTE: non-blocking assignments keep every register sampling the
  // pre-edge values, so evaluation order inside this block cannot matter.
  always_ff @(posedge clk_128M) begin
    if (rst) begin
      cnt_q    <= '0;
      led_q    <= 1'b0;
      toggle_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      led_q    <= led_d;
      toggle_q <= toggle_d;
    end
  end

  assign led    = led_q;
  assign toggle = toggle_q;

endmodule

// File: tb/tb_blink_led.sv
// Directed bench for blink_led: baseline, mid-period reset, truncation,
// minimum, clamp and tied-low-reset parameterisations run side by side.
module tb_blink_led;

  typedef struct packed {
    logic rst;
    logic led;
    logic tog;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic rst_tied = 1'b0;

  logic led4, tog4, led9, tog9, led1, tog1, ledc, togc, ledd, togd;

  int checks   = 0;
  int failures = 0;

  vec_t vecs[$];

  always #5 clk = ~clk;

  blink_led #(.CLK_FREQ(8), .BLINK_FREQ(1)) dut4 (
    .clk_128M(clk), .rst(rst), .led(led4), .toggle(tog4));
  blink_led #(.CLK_FREQ(9), .BLINK_FREQ(1)) dut9 (
    .clk_128M(clk), .rst(rst), .led(led9), .toggle(tog9));
  blink_led #(.CLK_FREQ(2), .BLINK_FREQ(1)) dut1 (
    .clk_128M(clk), .rst(rst), .led(led1), .toggle(tog1));
  blink_led #(.CLK_FREQ(1), .BLINK_FREQ(4)) dutc (
    .clk_128M(clk), .rst(rst), .led(ledc), .toggle(togc));
  blink_led dutd (
    .clk_128M(clk), .rst(rst_tied), .led(ledd), .toggle(togd));

  task automatic check(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic l, input logic t);
    vec_t v;
    v.rst = r;
    v.led = l;
    v.tog = t;
    vecs.push_back(v);
  endtask

  initial begin
    rst = 1'b1;

    // HALF_PERIOD = 4 schedule: {rst applied before edge, led and toggle after edge}
    add(1, 0, 0); add(1, 0, 0);
    add(0, 0, 0); add(0, 0, 0); add(0, 0, 0); add(0, 1, 1);
    add(0, 1, 0); add(0, 1, 0); add(0, 1, 0); add(0, 0, 1);
    add(0, 0, 0); add(0, 0, 0); add(0, 0, 0); add(0, 1, 1);
    // reset one cycle after the rise: partial count abandoned, no strobe
    add(1, 0, 0);
    add(0, 0, 0); add(0, 0, 0); add(0, 0, 0); add(0, 1, 1);
    add(0, 1, 0); add(0, 1, 0); add(0, 1, 0);
    // reset exactly at terminal count must not invert led or strobe
    add(1, 0, 0);
    add(0, 0, 0); add(0, 0, 0); add(0, 0, 0); add(0, 1, 1);
    add(0, 1, 0);

    #1;
    // power-up state before any clock edge
    check("pwr_led4", led4, 1'b0);  check("pwr_tog4", tog4, 1'b0);
    check("pwr_led1", led1, 1'b0);  check("pwr_tog1", tog1, 1'b0);
    check("pwr_ledc", ledc, 1'b0);  check("pwr_togc", togc, 1'b0);
    check("pwr_ledd", ledd, 1'b0);  check("pwr_togd", togd, 1'b0);

    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      step();
      check($sformatf("hp4_led[%0d]", i), led4, vecs[i].led);
      check($sformatf("hp4_tog[%0d]", i), tog4, vecs[i].tog);
      check($sformatf("trunc_led[%0d]", i), led9, vecs[i].led);
      check($sformatf("trunc_tog[%0d]", i), tog9, vecs[i].tog);
    end

    // HALF_PERIOD = 1 for both the minimum and the clamped instance
    rst = 1'b1;
    step();
    check("hp1_rst_led", led1, 1'b0);  check("hp1_rst_tog", tog1, 1'b0);
    check("clamp_rst_led", ledc, 1'b0); check("clamp_rst_tog", togc, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("hp1_led[%0d]", k), led1, (k % 2 == 0) ? 1'b1 : 1'b0);
      check($sformatf("hp1_tog[%0d]", k), tog1, 1'b1);
      check($sformatf("clamp_led[%0d]", k), ledc, (k % 2 == 0) ? 1'b1 : 1'b0);
      check($sformatf("clamp_tog[%0d]", k), togc, 1'b1);
    end
    rst = 1'b1;
    step();
    check("hp1_mid_rst_led", led1, 1'b0);  check("hp1_mid_rst_tog", tog1, 1'b0);
    rst = 1'b0;
    step();
    check("hp1_rel_led", led1, 1'b1);  check("hp1_rel_tog", tog1, 1'b1);

    // default instance, rst tied low: far from its 64000000-edge first rise
    for (int k = 0; k < 200; k++) step();
    check("def_led_low", ledd, 1'b0);
    check("def_tog_low", togd, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/blink_led.md
BLINK_LED -- requirements
Module: blink_led

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 128000000, giving the input clock frequency in Hz.
REQ-002 The block SHALL have parameter BLINK_FREQ, default 1, giving the LED blink frequency in Hz (one full on/off cycle).
REQ-003 The block SHALL have port clk_128M, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, reset that is synchronous and active-high.
REQ-005 The block SHALL have port led, output, 1 bit, the square-wave LED drive.
REQ-006 The block SHALL have port toggle, output, 1 bit, a one-cycle strobe marking each led transition.
REQ-007 Integrators SHALL be able to leave toggle unconnected; led and clk_128M alone SHALL suffice for use.

Function
REQ-008 HALF_PERIOD SHALL be CLK_FREQ / (2*BLINK_FREQ) with integer truncation, clamped to a minimum of 1.
REQ-009 The counter width SHALL be clog2(HALF_PERIOD), minimum 1 bit, so it never overflows before terminal count.
REQ-010 The counter SHALL increment by 1 each cycle while rst is low.
REQ-011 When the counter equals HALF_PERIOD-1, it SHALL wrap to 0 on the next edge and not pass through HALF_PERIOD.
REQ-012 led SHALL invert on the same edge the counter wraps, so each led level lasts exactly HALF_PERIOD cycles.
REQ-013 With default parameters, led SHALL toggle every 64000000 cycles, giving a 1 Hz, 50% duty square wave.
REQ-014 toggle SHALL be registered and high for exactly the one cycle after each led inversion, otherwise low.
REQ-015 When HALF_PERIOD is 1, led SHALL invert every cycle and toggle SHALL stay high continuously.
REQ-016 led and toggle SHALL be driven directly from flip-flops, with no combinational path from rst to an output.
REQ-017 Outputs SHALL have no dependence on signals other than clk_128M and rst.

Reset
REQ-018 While rst is high at a rising edge: counter SHALL go to 0, led to 0 and toggle to 0.
REQ-019 Reset asserted mid-period SHALL abandon the partial count; no toggle strobe SHALL be generated by reset.
REQ-020 After rst deasserts, the first led inversion SHALL occur on edge HALF_PERIOD counted from the first edge with rst low.
REQ-021 Power-up (initial) values of counter, led and toggle SHALL be 0, so the block runs correctly if rst is tied low.

Verification
REQ-022 Baseline, CLK_FREQ=8 and BLINK_FREQ=1 (HALF_PERIOD=4): apply rst for 2 cycles, then release -> led=0 for 4 cycles, led=1 for 4 cycles, repeating; toggle high on cycles 5, 9, 13, ...
REQ-023 Mid-period reset, same parameters: assert rst 1 cycle after led rises to 1 -> led=0 on the next edge, then 4 full cycles of 0 before the next rise.
REQ-024 Minimum case, CLK_FREQ=2 and BLINK_FREQ=1 (HALF_PERIOD=1): release rst -> led alternates 1,0,1,0 every cycle and toggle stays 1.
REQ-025 Truncation case, CLK_FREQ=9 and BLINK_FREQ=1 (HALF_PERIOD=4): release rst -> period is exactly 8 cycles with 50% duty.
REQ-026 Clamp case, CLK_FREQ=1 and BLINK_FREQ=4 (raw quotient 0): release rst -> behaves as HALF_PERIOD=1, with no X values on any output.
REQ-027 No-reset case: defaults with rst tied 0 -> led=0 at time 0, and the first rise occurs after 64000000 edges.
